mod_div_pow2: RTL and testbench

Sequential modular divide-by-power-of-two unit: computes oData = iData · 2^(−iShift) mod iMod for odd iMod, one modular halving per clock. It is the inverse of the modular doubling/quadrupling datapath: feeding its result through a 2^k modular multiplier returns the original operand. It sits between operand producers and consumers in the modular arithmetic pipeline and uses a valid/ready handshake on both sides.

---
 rtl/mod_div_pow2.sv | 110 +++++++++++
 tb/tb_mod_div_pow2.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_div_pow2.sv
// mod_div_pow2: sequential modular divide-by-power-of-two.
// Computes oData = iData * 2^(-iShift) mod iMod (iMod odd) by repeated
// modular halving, with valid/ready handshakes on both sides.
// Optional build macro MOD_DIV_POW2_RADIX4_EN: two chained halvings per
// RUN cycle (divide by 4) while at least two steps remain.
module mod_div_pow2 #(
  parameter int BITWIDTH = 32,
  parameter int SHIFTW   = 6
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iMod,
  input  logic [SHIFTW-1:0]   iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic [BITWIDTH-1:0] mod_q, mod_d;
  logic [SHIFTW-1:0]   count_q, count_d;

  // One modular halving: odd values get M added first so the sum is even;
  // the sum keeps its carry bit so the shift cannot lose the top bit.
  function automatic logic [BITWIDTH-1:0] halve(input logic [BITWIDTH-1:0] x,
                                                input logic [BITWIDTH-1:0] m);
    logic [BITWIDTH:0] sum;
    sum = {1'b0, x} + (x[0] ? {1'b0, m} : {(BITWIDTH+1){1'b0}});
    return sum[BITWIDTH:1];
  endfunction

  // State, operand, modulus and remaining-step registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      data_q  <= '0;
      mod_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      count_q <= count_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mod_d   = mod_q;
    count_d = count_q;
    oReady  = 1'b0;
    oValid  = 1'b0;
    oData   = '0;
    case (state_q)
      IDLE: begin
        oReady = iRstN;
        if (iValid) begin
          data_d  = iData;
          mod_d   = iMod;
          count_d = iShift;
          state_d = (iShift != '0) ? RUN : DONE;
        end
      end
      RUN: begin
`ifdef MOD_DIV_POW2_RADIX4_EN
        if (count_q > SHIFTW'(1)) begin
          data_d  = halve(halve(data_q, mod_q), mod_q);
          count_d = count_q - SHIFTW'(2);
          if (count_q == SHIFTW'(2)) begin
            state_d = DONE;
          end
        end else begin
          data_d  = halve(data_q, mod_q);
          count_d = '0;
          state_d = DONE;
        end
`else
        data_d  = halve(data_q, mod_q);
        count_d = count_q - SHIFTW'(1);
        if (count_q <= SHIFTW'(1)) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        oValid = 1'b1;
        oData  = data_q;
        if (iReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_div_pow2.sv
// tb_mod_div_pow2: scoreboard-based self-checking bench for mod_div_pow2.
// Expected results are pushed when an operand is accepted and popped when
// the unit presents oValid. Honours MOD_DIV_POW2_RADIX4_EN for latency.
module tb_mod_div_pow2;

  localparam int BW = 32;
  localparam int SW = 6;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [BW-1:0] iData = '0;
  logic [BW-1:0] iMod = '0;
  logic [SW-1:0] iShift = '0;
  logic          oValid;
  logic          iReady = 1'b0;
  logic [BW-1:0] oData;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  mod_div_pow2 #(.BITWIDTH(BW), .SHIFTW(SW)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady),
    .iData(iData), .iMod(iMod), .iShift(iShift), .oValid(oValid),
    .iReady(iReady), .oData(oData)
  );

  always #5 iClk = ~iClk;

  // Reference: multiply by the inverse of 2 (which is (M+1)/2 for odd M) k times.
  function automatic logic [BW-1:0] model_div(input logic [BW-1:0] x, input logic [BW-1:0] m, input int k);
    longint unsigned mm, inv2, r;
    mm = 64'(m);
    inv2 = (mm + 1) >> 1;
    r = 64'(x) % mm;
    for (int i = 0; i < k; i++) r = (r * inv2) % mm;
    return r[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] model_mul2k(input logic [BW-1:0] y, input logic [BW-1:0] m, input int k);
    longint unsigned r;
    r = 64'(y);
    for (int i = 0; i < k; i++) r = (r * 2) % 64'(m);
    return r[BW-1:0];
  endfunction

  function automatic int exp_latency(input int k);
`ifdef MOD_DIV_POW2_RADIX4_EN
    return (k + 1) / 2 + 1;
`else
    return k + 1;
`endif
  endfunction

  // Accept one operand, push its expected result, wait for oValid, then compare.
  task automatic do_op(input logic [BW-1:0] x, input logic [BW-1:0] m, input int k,
                       input logic [BW-1:0] expected, input string name,
                       input bit check_inverse);
    int cycles;
    logic [BW-1:0] want;
    @(negedge iClk);
    checks++;
    if (oReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s ready_before_accept got %b want 1", name, oReady);
    end
    iData = x; iMod = m; iShift = SW'(k); iValid = 1'b1;
    @(posedge iClk);
    exp_q.push_back(expected);
    @(negedge iClk);
    iValid = 1'b0;
    cycles = 1;
    while (oValid !== 1'b1 && cycles < 200) begin
      checks++;
      if (oReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s ready_while_busy got %b want 0", name, oReady);
      end
      @(negedge iClk);
      cycles++;
    end
    checks++;
    if (oValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s timeout got no oValid after %0d cycles", name, cycles);
      void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (cycles != exp_latency(k)) begin
      errors++;
      $display("[TB] FAIL %s latency got %0d want %0d", name, cycles, exp_latency(k));
    end
    want = exp_q.pop_front();
    checks++;
    if (oData !== want) begin
      errors++;
      $display("[TB] FAIL %s data got 0x%0h want 0x%0h", name, oData, want);
    end
    if (check_inverse) begin
      checks++;
      if (model_mul2k(oData, m, k) !== x) begin
        errors++;
        $display("[TB] FAIL %s inverse got 0x%0h want 0x%0h", name, model_mul2k(oData, m, k), x);
      end
    end
    iReady = 1'b1;
    @(negedge iClk);
    iReady = 1'b0;
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    repeat (3) @(negedge iClk);
    checks++;
    if (oValid !== 1'b0 || oData !== '0 || oReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values got v=%b d=0x%0h r=%b want 0 0 0", oValid, oData, oReady);
    end
    iRstN = 1'b1;
    @(negedge iClk);
    checks++;
    if (oReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b want 1", oReady);
    end
  endtask

  task automatic test_directed();
    do_op(32'd5, 32'd13, 2, 32'd11, "m13_x5_k2", 1'b1);
    do_op(32'hFFFFFFF9, 32'hFFFFFFFB, 1, 32'hFFFFFFFA, "carry_odd", 1'b1);
    do_op(32'hFFFFFFFA, 32'hFFFFFFFB, 1, 32'h7FFFFFFD, "carry_even", 1'b1);
    do_op(32'd7, 32'd13, 0, 32'd7, "k0", 1'b1);
    do_op(32'd1, 32'd13, 63, model_div(32'd1, 32'd13, 63), "k63", 1'b1);
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] held;
    @(negedge iClk);
    iData = 32'd5; iMod = 32'd13; iShift = 6'd2; iValid = 1'b1;
    @(posedge iClk);
    exp_q.push_back(32'd11);
    @(negedge iClk);
    for (int i = 0; i < 4; i++) begin
      iValid = i[0];
      iData = 32'd3;
      @(negedge iClk);
    end
    iValid = 1'b0;
    held = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      iValid = i[0];
      checks++;
      if (oValid !== 1'b1 || oData !== held || oReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold cyc %0d got v=%b d=%0d r=%b want 1 %0d 0",
                 i, oValid, oData, oReady, held);
      end
      @(negedge iClk);
    end
    iValid = 1'b1;
    iReady = 1'b1;
    @(negedge iClk);
    iReady = 1'b0;
    iValid = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handshake_no_accept got v=%b r=%b want 0 1", oValid, oReady);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge iClk);
    iData = 32'd5; iMod = 32'd13; iShift = 6'd5; iValid = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iValid = 1'b0;
    @(negedge iClk);
    iRstN = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oData !== '0 || oReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run got v=%b d=0x%0h r=%b want 0 0 0", oValid, oData, oReady);
    end
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    checks++;
    if (oReady !== 1'b1 || oValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run_release got r=%b v=%b want 1 0", oReady, oValid);
    end
    do_op(32'd5, 32'd13, 2, 32'd11, "after_reset", 1'b1);
  endtask

  task automatic test_random_sweep();
    logic [BW-1:0] m, x;
    int k;
    for (int i = 0; i < 24; i++) begin
      m = BW'($urandom_range(3, 65535)) | 32'd1;
      x = BW'($urandom) % m;
      k = $urandom_range(0, 63);
      do_op(x, m, k, model_div(x, m, k), "sweep", 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
